// File: rtl/acs_unit.sv
// Viterbi add-compare-select stage: one trellis step per valid cycle, with
// per-state survivor decisions, MSB metric normalization and best-state search.

module acs_node #(
    parameter int M = 8,
    parameter int R = 2
) (
    input  logic [M-1:0] pm0,
    input  logic [M-1:0] pm1,
    input  logic [R-1:0] d0,
    input  logic [R-1:0] d1,
    output logic [M-1:0] sel,
    output logic         dec
);
    logic [M:0]   s0, s1;
    logic [M-1:0] c0, c1;

    always_comb begin
        s0  = {1'b0, pm0} + {{(M+1-R){1'b0}}, d0};
        s1  = {1'b0, pm1} + {{(M+1-R){1'b0}}, d1};
        c0  = s0[M] ? '1 : s0[M-1:0];
        c1  = s1[M] ? '1 : s1[M-1:0];
        // strict compare: a tie keeps the b=0 predecessor
        dec = (c1 < c0);
        sel = dec ? c1 : c0;
    end
endmodule

module acs_unit #(
    parameter int r       = 2,
    parameter int K       = 3,
    parameter int M       = 8,
    parameter int PM_INIT = 16,
    localparam int N      = 1 << (K-1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             start,
    input  logic [2*N*r-1:0] dis_in,
    output logic             dec_valid,
    output logic [N-1:0]     dec_out,
    output logic [N*M-1:0]   pm_out,
    output logic [K-2:0]     best_state,
    output logic             norm_evt
);
    logic [N-1:0][M-1:0]   pm_q, src, sel, nxt;
    logic [2*N-1:0][r-1:0] dis;
    logic [N-1:0]          dec;
    logic                  norm;
    logic [K-2:0]          best;
    logic [M-1:0]          bmin;
    logic [1:0]            vld_pipe;

    assign dis         = dis_in;
    assign vld_pipe[0] = in_valid;

    always_comb begin
        for (int s = 0; s < N; s++)
            src[s] = start ? ((s == 0) ? '0 : M'(PM_INIT)) : pm_q[s];
    end

    // predecessors of n are p = ((n<<1) & (N-1)) | b, input bit u = n[K-2]
    for (genvar n = 0; n < N; n++) begin : g_node
        localparam int U  = n >> (K-2);
        localparam int P0 = (n << 1) & (N-1);
        acs_node #(.M(M), .R(r)) u_node (
            .pm0 (src[P0]),
            .pm1 (src[P0+1]),
            .d0  (dis[2*P0+U]),
            .d1  (dis[2*(P0+1)+U]),
            .sel (sel[n]),
            .dec (dec[n])
        );
    end

    always_comb begin
        norm = 1'b1;
        for (int s = 0; s < N; s++)
            norm = norm & sel[s][M-1];
        for (int s = 0; s < N; s++) begin
            nxt[s] = sel[s];
            if (norm)
                nxt[s][M-1] = 1'b0;
        end
    end

    // lowest index wins ties because only a strictly smaller metric replaces it
    always_comb begin
        best = '0;
        bmin = nxt[0];
        for (int s = 1; s < N; s++) begin
            if (nxt[s] < bmin) begin
                bmin = nxt[s];
                best = (K-1)'(s);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_pipe[1] <= 1'b0;
            norm_evt    <= 1'b0;
            pm_q        <= '0;
            dec_out     <= '0;
            best_state  <= '0;
        end else begin
            vld_pipe[1] <= vld_pipe[0];
            norm_evt    <= vld_pipe[0] & norm;
            if (vld_pipe[0]) begin
                pm_q       <= nxt;
                dec_out    <= dec;
                best_state <= best;
            end
        end
    end

    assign dec_valid = vld_pipe[1];
    assign pm_out    = pm_q;
endmodule

// File: tb/tb_acs_unit.sv
// Bench for acs_unit: directed vector table, normalization run, stall/reset
// sequences and random steps against a plain integer trellis model.

module tb_acs_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        start = 1'b0;
    logic [15:0] dis_in = '0;
    logic        dec_valid;
    logic [3:0]  dec_out;
    logic [31:0] pm_out;
    logic [1:0]  best_state;
    logic        norm_evt;

    int checks = 0;
    int failures = 0;

    int m_pm[4];
    int m_dec, m_best, m_norm, m_dv;

    acs_unit #(.r(2), .K(3), .M(8), .PM_INIT(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .start      (start),
        .dis_in     (dis_in),
        .dec_valid  (dec_valid),
        .dec_out    (dec_out),
        .pm_out     (pm_out),
        .best_state (best_state),
        .norm_evt   (norm_evt)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          st;
        logic [15:0] dis;
        logic [31:0] pm;
        logic [3:0]  dec;
        logic [1:0]  best;
        bit          norm;
    } vec_t;

    function automatic int fld(logic [15:0] d, int g);
        logic [15:0] t;
        t = (d >> (2*g)) & 16'h3;
        return int'(t);
    endfunction

    function automatic logic [39:0] act();
        return {dec_valid, norm_evt, best_state, dec_out, pm_out};
    endfunction

    function automatic logic [39:0] model_exp();
        logic [31:0] p;
        for (int s = 0; s < 4; s++) p[s*8 +: 8] = m_pm[s][7:0];
        return {m_dv[0], m_norm[0], m_best[1:0], m_dec[3:0], p};
    endfunction

    task automatic model_reset();
        for (int s = 0; s < 4; s++) m_pm[s] = 0;
        m_dec = 0; m_best = 0; m_norm = 0; m_dv = 0;
    endtask

    task automatic model_step(bit v, bit s, logic [15:0] d);
        int src[4];
        int nw[4];
        int c0, c1, p0;
        bit hi;
        if (!v) begin
            m_dv = 0;
            m_norm = 0;
        end else begin
            for (int p = 0; p < 4; p++) src[p] = s ? (p == 0 ? 0 : 16) : m_pm[p];
            m_dec = 0;
            for (int n = 0; n < 4; n++) begin
                p0 = (n * 2) % 4;
                c0 = src[p0] + fld(d, 2*p0 + n/2);
                c1 = src[p0+1] + fld(d, 2*(p0+1) + n/2);
                if (c0 > 255) c0 = 255;
                if (c1 > 255) c1 = 255;
                if (c1 < c0) begin
                    nw[n] = c1;
                    m_dec = m_dec | (1 << n);
                end else nw[n] = c0;
            end
            hi = 1'b1;
            for (int n = 0; n < 4; n++) if (nw[n] < 128) hi = 1'b0;
            if (hi) for (int n = 0; n < 4; n++) nw[n] = nw[n] - 128;
            m_best = 0;
            for (int n = 1; n < 4; n++) if (nw[n] < nw[m_best]) m_best = n;
            for (int n = 0; n < 4; n++) m_pm[n] = nw[n];
            m_dv = 1;
            m_norm = hi ? 1 : 0;
        end
    endtask

    task automatic check(string nm, logic [39:0] a, logic [39:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, a, e);
        end
    endtask

    task automatic drive(bit v, bit s, logic [15:0] d);
        @(negedge clk);
        in_valid = v;
        start = s;
        dis_in = d;
        @(posedge clk);
        #1;
        model_step(v, s, d);
    endtask

    function automatic logic [31:0] all4(int x);
        return {x[7:0], x[7:0], x[7:0], x[7:0]};
    endfunction

    vec_t vt[6];
    logic [39:0] snap;
    int dvc;

    initial begin
        vt[0] = '{1'b1, 16'h0000, {8'd16, 8'd0, 8'd16, 8'd0}, 4'b0000, 2'd0, 1'b0};
        vt[1] = '{1'b0, 16'hFFCF, {8'd3, 8'd3, 8'd3, 8'd3},   4'b0000, 2'd0, 1'b0};
        vt[2] = '{1'b0, 16'h0033, {8'd3, 8'd3, 8'd3, 8'd6},   4'b0000, 2'd1, 1'b0};
        vt[3] = '{1'b0, 16'h0003, {8'd3, 8'd3, 8'd3, 8'd3},   4'b0101, 2'd0, 1'b0};
        vt[4] = '{1'b1, 16'h0000, {8'd16, 8'd0, 8'd16, 8'd0}, 4'b0000, 2'd0, 1'b0};
        vt[5] = '{1'b1, 16'h0000, {8'd16, 8'd0, 8'd16, 8'd0}, 4'b0000, 2'd0, 1'b0};

        model_reset();
        repeat (3) @(posedge clk);
        #1 check("reset_state", act(), 40'h0);
        @(negedge clk) rst = 1'b1;

        // directed table, applied back to back
        foreach (vt[i]) begin
            drive(1'b1, vt[i].st, vt[i].dis);
            check($sformatf("vec%0d", i), act(),
                  {1'b1, vt[i].norm, vt[i].best, vt[i].dec, vt[i].pm});
        end

        // long all-3 run up to the first normalization
        drive(1'b1, 1'b1, 16'hFFFF);
        check("run_step1", act(), {1'b1, 1'b0, 2'd0, 4'd0, 8'd19, 8'd3, 8'd19, 8'd3});
        for (int n = 2; n <= 43; n++) begin
            drive(1'b1, 1'b0, 16'hFFFF);
            check($sformatf("run_step%0d", n), act(),
                  {1'b1, (n == 43), 2'd0, 4'd0, all4(n == 43 ? 1 : 3*n)});
        end

        // stall: valid, 5 idle, valid, idle
        dvc = 0;
        drive(1'b1, 1'b0, 16'h1B6E);
        if (dec_valid) dvc++;
        check("stall_pre", act(), model_exp());
        snap = act();
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b1, 16'($urandom));
            if (dec_valid) dvc++;
            check($sformatf("stall_hold%0d", i), act(), {2'b00, snap[37:0]});
        end
        drive(1'b1, 1'b0, 16'h4E21);
        if (dec_valid) dvc++;
        check("stall_post", act(), model_exp());
        drive(1'b0, 1'b0, 16'h0);
        if (dec_valid) dvc++;
        check("stall_dv_count", 40'(dvc), 40'd2);

        // asynchronous reset in the middle of a burst
        drive(1'b1, 1'b1, 16'hA5C3);
        drive(1'b1, 1'b0, 16'h3C5A);
        @(negedge clk);
        in_valid = 1'b1;
        #2 rst = 1'b0;
        #1 check("rst_async", act(), 40'h0);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b0;
        drive(1'b1, 1'b0, 16'h9D72);
        check("rst_nostart", act(), model_exp());
        drive(1'b1, 1'b1, 16'hFFFF);
        check("rst_restart", act(), {1'b1, 1'b0, 2'd0, 4'd0, 8'd19, 8'd3, 8'd19, 8'd3});

        // random steps against the model
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, 16'($urandom));
            check($sformatf("rand%0d", i), act(), model_exp());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/acs_unit.md
Name: acs_unit

Overview:
- Add-compare-select stage of the Viterbi decoder, directly downstream of the branch-metric unit.
- Each valid step consumes the 2*2^(K-1) branch distances the BMU produces and updates one path metric per trellis state.
- Emits one survivor decision bit per state for the traceback memory, plus the current path metrics and the best state.
- Path metrics are kept bounded by MSB normalization and saturation.

Parameters:
- r, 2, codeword width; width of each branch distance field.
- K, 3, constraint length; N = 2^(K-1) states.
- M, 8, path metric width in bits.
- PM_INIT, 16, initial metric loaded for every state except state 0 on start.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active low.
- in_valid  in  1  dis_in holds a valid set of branch distances this cycle.
- start  in  1  first step of a frame; sampled only when in_valid=1.
- dis_in  in  2*N*r  branch distances; field g = dis_in[(g+1)*r-1 : g*r].
- dec_valid  out  1  dec_out / pm_out / best_state updated this cycle.
- dec_out  out  N  survivor decision bit per next state; bit s belongs to state s.
- pm_out  out  N*M  path metrics; state s at pm_out[(s+1)*M-1 : s*M].
- best_state  out  K-1  index of the minimum metric in pm_out.
- norm_evt  out  1  pulses with dec_valid when normalization was applied.

Behaviour:
- Reset (rst=0, asynchronous):
  - all outputs 0 and all path metric registers 0;
  - dec_valid deasserts immediately;
  - a reset mid-frame discards all state, and the next frame must begin with start.
- Trellis convention:
  - from state p with input bit u, next state n = (p>>1) | (u<<(K-2));
  - branch field index g = 2*p + u.
- Predecessors of n:
  - u = n[K-2];
  - p_b = ((n<<1) & (N-1)) | b for b in {0,1}.
- Candidate metrics:
  - c_b = PM[p_b] + dis[2*p_b + u], computed in M+1 bits;
  - saturate to 2^M-1 if the result exceeds it.
- Select:
  - new PM[n] = min(c_0, c_1);
  - dec_out[n] = 1 only when c_1 < c_0 (strict), so a tie selects b=0.
- Start step (in_valid=1, start=1): source metrics are {PM[0]=0, PM[s>0]=PM_INIT} rather than the registers.
- Normalization:
  - if every selected metric has bit M-1 set, clear bit M-1 in all N metrics before registering;
  - norm_evt=1 on that step.
- Latency: one cycle. Values in the cycle after in_valid=1 are registered into PM, dec_out, pm_out and best_state, with dec_valid=1.
- Stall: in_valid=0 means PM, dec_out, pm_out and best_state hold; dec_valid=0 and norm_evt=0.
- best_state:
  - argmin of the newly registered metrics;
  - ties resolve to the lowest state index;
  - registered together with pm_out.
- Back-to-back in_valid every cycle is supported, so throughput is one trellis step per clock.
- start with in_valid=0 is ignored.
- Bounds: with r-bit distances and M >= r+K+2, metric spread never reaches 2^(M-1), so normalization never corrupts ordering. Saturation is a safety net only.

Test Plan:
- Reset then start, dis_in=all 0, in_valid 1 cycle -> next cycle:
  - dec_valid=1, pm_out={0,16,0,16} for states 0..3;
  - dec_out=0000, best_state=0, norm_evt=0.
- Start followed by 42 further steps, all distances 3 (dis_in=16'hFFFF):
  - after step 1, pm={3,19,3,19}; step n>=2 gives all metrics 3n;
  - step 43 gives all metrics 1 and norm_evt=1;
  - dec_out=0000 throughout (ties pick b=0).
- After start step with zero distances, step with dis field 2=0 and all other fields 3:
  - state 0 candidates c0=0+3, c1=16+0 -> PM[0]=3, dec_out[0]=0;
  - then load field 0=3, field 2=0 with PM[1] preset lower by a prior step -> dec_out[0]=1 when c1<c0 strictly.
- Stall: pulse in_valid, hold low 5 cycles, pulse again:
  - pm_out, dec_out and best_state stay unchanged during the gap;
  - dec_valid is high exactly two cycles.
- Assert rst mid-frame during in_valid burst:
  - outputs go 0 immediately and the following in_valid without start uses zeroed metrics;
  - with start, the frame re-initializes to {0,16,16,16}-based results.
- Back-to-back start: start asserted on two consecutive valid steps -> the second step ignores the first step's metrics and reproduces the {0,16,0,16} result for zero distances.
